// File: rtl/percept_ctrl.sv
// Host-side sequencer for the percept serial chain: serialises a weight/data
// pair, strobes mul/acc, and optionally deserialises the result chain.
module percept_ctrl #(
  parameter int WIDTH    = 32,
  parameter int RES_BITS = 64
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                start,
  input  logic [WIDTH-1:0]    weight,
  input  logic [WIDTH-1:0]    data,
  input  logic                read_en,
  output logic                ready,
  output logic                done,
  output logic                res_valid,
  output logic [RES_BITS-1:0] res,
  output logic                p_in,
  output logic                p_shift,
  output logic                p_mul,
  output logic                p_acc,
  output logic                p_in_res,
  output logic                p_shift_res,
  input  logic                p_out_res
);

  // state | meaning
  // IDLE  | ready for a new pair
  // LOAD  | shifting weight then data into the operand chain
  // MUL   | multiply strobe
  // GAP1  | settle cycle between strobes
  // ACC   | accumulate strobe
  // GAP2  | settle cycle before read / completion
  // READ  | shifting the result chain out, MSB first
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, LOAD, MUL, GAP1, ACC, GAP2, READ, DONE} state_t;

  localparam int MAXC = (2*WIDTH > RES_BITS) ? 2*WIDTH : RES_BITS;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] LOAD_LAST = CW'(2*WIDTH - 1);
  localparam logic [CW-1:0] READ_LAST = CW'(RES_BITS - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-2:0]  sreg;
  logic [RES_BITS-2:0] cap;
  logic                rd;

  assign p_in_res = 1'b0;

  // Outputs describe the cycle that follows each edge, so every p_* is a flop.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      cap         <= '0;
      rd          <= 1'b0;
      res         <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      res_valid   <= 1'b0;
      p_in        <= 1'b0;
      p_shift     <= 1'b0;
      p_mul       <= 1'b0;
      p_acc       <= 1'b0;
      p_shift_res <= 1'b0;
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            ready   <= 1'b0;
            rd      <= read_en;
            p_in    <= weight[WIDTH-1];
            sreg    <= {weight[WIDTH-2:0], data};
            p_shift <= 1'b1;
            cnt     <= '0;
          end
        end
        LOAD: begin
          if (cnt == LOAD_LAST) begin
            state   <= MUL;
            p_shift <= 1'b0;
            p_in    <= 1'b0;
            p_mul   <= 1'b1;
          end else begin
            cnt  <= cnt + 1'b1;
            p_in <= sreg[2*WIDTH-2];
            sreg <= {sreg[2*WIDTH-3:0], 1'b0};
          end
        end
        MUL: begin
          state <= GAP1;
          p_mul <= 1'b0;
        end
        GAP1: begin
          state <= ACC;
          p_acc <= 1'b1;
        end
        ACC: begin
          state <= GAP2;
          p_acc <= 1'b0;
        end
        GAP2: begin
          if (rd) begin
            state       <= READ;
            p_shift_res <= 1'b1;
            cnt         <= '0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        READ: begin
          cap <= {cap[RES_BITS-3:0], p_out_res};
          if (cnt == READ_LAST) begin
            // last bit goes straight into res so it updates in one step
            res         <= {cap, p_out_res};
            state       <= DONE;
            done        <= 1'b1;
            res_valid   <= 1'b1;
            p_shift_res <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_percept_ctrl.sv
// Directed bench for percept_ctrl with a behavioural percept chain model.
module tb_percept_ctrl;
  localparam int W  = 32;
  localparam int RB = 64;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  weight = '0;
  logic [W-1:0]  data = '0;
  logic          read_en = 1'b0;
  logic          ready, done, res_valid;
  logic [RB-1:0] res;
  logic          p_in, p_shift, p_mul, p_acc, p_in_res, p_shift_res, p_out_res;

  int errors = 0;
  int checks = 0;

  percept_ctrl #(.WIDTH(W), .RES_BITS(RB)) dut (
    .clk(clk), .nRst(nRst), .start(start), .weight(weight), .data(data),
    .read_en(read_en), .ready(ready), .done(done), .res_valid(res_valid),
    .res(res), .p_in(p_in), .p_shift(p_shift), .p_mul(p_mul), .p_acc(p_acc),
    .p_in_res(p_in_res), .p_shift_res(p_shift_res), .p_out_res(p_out_res)
  );

  always #5 clk = ~clk;

  // percept chain model: operand chain, multiplier, accumulator, result chain
  logic          use_model = 1'b0;
  logic [63:0]   forced_res = '0;
  logic [2*W-1:0] opsr;
  logic [63:0]   prod, acc, res_chain;

  assign p_out_res = res_chain[63];

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      opsr <= '0; prod <= '0; acc <= '0; res_chain <= '0;
    end else begin
      if (p_shift) opsr <= {opsr[2*W-2:0], p_in};
      if (p_mul) prod <= {32'h0, opsr[2*W-1:W]} * {32'h0, opsr[W-1:0]};
      if (p_acc) begin
        if (use_model) acc <= acc + prod;
        res_chain <= use_model ? acc + prod : forced_res;
      end
      if (p_shift_res) res_chain <= {res_chain[62:0], p_in_res};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one transaction from its cycle 0 through cycle lat, checking every
  // strobe per cycle against the expected timeline. Optional start pulses at
  // cycles pa/pb must be ignored.
  task automatic run_txn(input logic [W-1:0] w, input logic [W-1:0] d, input logic r,
                         input int lat, input int pa, input int pb,
                         input logic [63:0] exp_res, input string tag);
    logic [2*W-1:0] ops;
    int b_sh, b_in, b_mul, b_acc, b_done, b_val, b_sr, b_inr, b_rdy, n_done;
    logic [63:0] res_at_done;
    ops = {w, d};
    b_sh = 0; b_in = 0; b_mul = 0; b_acc = 0; b_done = 0; b_val = 0;
    b_sr = 0; b_inr = 0; b_rdy = 0; n_done = 0; res_at_done = '0;
    @(negedge clk);
    check({tag, "_ready_at_start"}, 64'(ready), 64'(1));
    weight = w; data = d; read_en = r; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; weight = ~w; data = ~d; read_en = ~r;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      start = (n == pa) || (n == pb);
      if (p_shift !== (n >= 1 && n <= 2*W)) b_sh++;
      if (n <= 2*W && p_in !== ops[2*W-n]) b_in++;
      if (p_mul !== (n == 2*W+1)) b_mul++;
      if (p_acc !== (n == 2*W+3)) b_acc++;
      if (done !== (n == lat)) b_done++;
      if (res_valid !== (n == lat && r)) b_val++;
      if (p_shift_res !== (r && n >= 2*W+5 && n <= 2*W+4+RB)) b_sr++;
      if (p_in_res !== 1'b0) b_inr++;
      if (ready !== 1'b0) b_rdy++;
      if (done === 1'b1) n_done++;
      if (n == lat) res_at_done = res;
    end
    check({tag, "_p_shift_bad_cycles"}, 64'(b_sh), 64'(0));
    check({tag, "_p_in_bad_cycles"}, 64'(b_in), 64'(0));
    check({tag, "_p_mul_bad_cycles"}, 64'(b_mul), 64'(0));
    check({tag, "_p_acc_bad_cycles"}, 64'(b_acc), 64'(0));
    check({tag, "_done_bad_cycles"}, 64'(b_done), 64'(0));
    check({tag, "_done_count"}, 64'(n_done), 64'(1));
    check({tag, "_res_valid_bad_cycles"}, 64'(b_val), 64'(0));
    check({tag, "_p_shift_res_bad_cycles"}, 64'(b_sr), 64'(0));
    check({tag, "_p_in_res_bad_cycles"}, 64'(b_inr), 64'(0));
    check({tag, "_ready_low_bad_cycles"}, 64'(b_rdy), 64'(0));
    check({tag, "_res"}, res_at_done, exp_res);
  endtask

  typedef struct {
    logic [W-1:0] w;
    logic [W-1:0] d;
    logic         rd;
    logic         model;
    logic [63:0]  forced;
    int           lat;
    logic [63:0]  exp_res;
    string        tag;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [63:0] b2b_r[3];
    int k, last, holdbad, b_rst;

    vecs[0] = '{32'h8000_0001, 32'h0000_0003, 1'b0, 1'b0, 64'h0, 69, 64'h0, "load"};
    vecs[1] = '{32'hCAFE_0001, 32'h1234_5678, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 133,
                64'h0123_4567_89AB_CDEF, "read"};
    vecs[2] = '{32'd2000, 32'd1000, 1'b1, 1'b1, 64'h0, 133, 64'h0000_0000_001E_8480, "e2e"};
    vecs[3] = '{32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0, 64'h0, 69,
                64'h0000_0000_001E_8480, "noread_hold"};
    b2b_r[0] = 64'h1; b2b_r[1] = 64'hFFFF_FFFF_FFFF_FFFF; b2b_r[2] = 64'h0;

    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready), 64'(1));
    check("reset_outputs", 64'({done, res_valid, p_in, p_shift, p_mul, p_acc, p_in_res, p_shift_res}), 64'(0));
    check("reset_res", res, 64'h0);
    nRst = 1'b1;

    // abort mid-LOAD at cycle 10
    @(negedge clk);
    weight = 32'hFFFF_FFFF; data = 32'hFFFF_FFFF; read_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    check("abort_pre_p_shift", 64'(p_shift), 64'(1));
    nRst = 1'b0;
    #1;
    check("abort_outputs", 64'({done, res_valid, p_in, p_shift, p_mul, p_acc, p_in_res, p_shift_res}), 64'(0));
    check("abort_ready", 64'(ready), 64'(1));
    check("abort_res", res, 64'h0);
    @(negedge clk);
    nRst = 1'b1;
    b_rst = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || res_valid !== 1'b0 || ready !== 1'b1) b_rst++;
    end
    check("abort_no_followup", 64'(b_rst), 64'(0));

    for (int i = 0; i < 4; i++) begin
      use_model = vecs[i].model;
      forced_res = vecs[i].forced;
      run_txn(vecs[i].w, vecs[i].d, vecs[i].rd, vecs[i].lat, 0, 0, vecs[i].exp_res, vecs[i].tag);
    end

    // ignored starts at cycles 5 and 133, then restart at cycle 134
    use_model = 1'b0;
    forced_res = 64'hDEAD_BEEF_CAFE_F00D;
    run_txn(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 133, 5, 133, 64'hDEAD_BEEF_CAFE_F00D, "hs_first");
    run_txn(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 69, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, "hs_second");

    // back-to-back with start tied high
    @(negedge clk);
    forced_res = b2b_r[0];
    weight = 32'h0000_0011; data = 32'h0000_0022; read_en = 1'b1; start = 1'b1;
    k = 0; last = -1; holdbad = 0;
    for (int n = 0; n < 3*134 + 20 && k < 3; n++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        check("b2b_res", res, b2b_r[k]);
        check("b2b_done", 64'(done), 64'(1));
        if (k > 0) check("b2b_spacing", 64'(n - last), 64'(134));
        last = n;
        k++;
        if (k < 3) forced_res = b2b_r[k];
        if (k == 3) start = 1'b0;
      end else if (k > 0 && res !== b2b_r[k-1]) begin
        holdbad++;
      end
    end
    start = 1'b0;
    check("b2b_pulse_count", 64'(k), 64'(3));
    check("b2b_res_hold", 64'(holdbad), 64'(0));
    repeat (3) @(negedge clk);
    check("b2b_idle_ready", 64'(ready), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
